// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXECUTE/MEM/WB sequencer for a multi-cycle RV32I core.
// Drives datapath write strobes and memory handshakes, counts retired instructions,
// halts on ebreak and traps on illegal opcodes, bad formats or memory timeouts.
module multicycle_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [6:0]       i_opcode,
    input  logic [5:0]       i_format,
    input  logic             i_ebreak,
    input  logic             i_branch_taken,
    input  logic             i_imem_ready,
    input  logic             i_dmem_ready,
    output logic             o_imem_req,
    output logic             o_ir_we,
    output logic             o_pc_we,
    output logic [1:0]       o_pc_sel,
    output logic             o_rf_we,
    output logic             o_dmem_ren,
    output logic             o_dmem_wen,
    output logic             o_retire,
    output logic             o_halt,
    output logic             o_trap,
    output logic [2:0]       o_state,
    output logic [CNT_W-1:0] o_retired
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5,
        S_TRAP    = 3'd6,
        S_BAD     = 3'd7
    } state_t;

    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Last tolerated waiting-cycle index; ready still counts in the TIMEOUT-th cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_wait_cnt;
    logic [CNT_W-1:0] r_retired;

    // Raw strobes from the FSM, before the reset override.
    logic       w_imem_req;
    logic       w_ir_we;
    logic       w_pc_we;
    logic [1:0] w_pc_sel;
    logic       w_rf_we;
    logic       w_dmem_ren;
    logic       w_dmem_wen;
    logic       w_retire;

    // Instruction classification; the IR is stable from DECODE onward.
    logic w_fmt_onehot;
    logic w_is_load;
    logic w_is_store;
    logic w_is_branch;
    logic w_is_jal;
    logic w_is_jalr;
    logic w_timeout;
    logic w_waiting;

    assign w_fmt_onehot = (i_format != 6'd0) && ((i_format & (i_format - 6'd1)) == 6'd0);
    assign w_is_load    = (i_opcode == OP_LOAD);
    assign w_is_store   = i_format[2];
    assign w_is_branch  = i_format[3];
    assign w_is_jal     = i_format[5];
    assign w_is_jalr    = (i_opcode == OP_JALR);
    assign w_timeout    = (r_wait_cnt == TO_LAST);
    assign w_waiting    = ((r_state == S_FETCH) && !i_imem_ready) ||
                          ((r_state == S_MEM)   && !i_dmem_ready);

    // Next-state and strobe decode; everything defaults to idle.
    always_comb begin
        w_next     = r_state;
        w_imem_req = 1'b0;
        w_ir_we    = 1'b0;
        w_pc_we    = 1'b0;
        w_pc_sel   = PC_PLUS4;
        w_rf_we    = 1'b0;
        w_dmem_ren = 1'b0;
        w_dmem_wen = 1'b0;
        w_retire   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_imem_req = 1'b1;
                if (i_imem_ready) begin
                    w_ir_we = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_DECODE: begin
                if (i_opcode == OP_SYSTEM) begin
                    // Only ebreak is supported among SYSTEM instructions.
                    w_next = i_ebreak ? S_HALT : S_TRAP;
                end else if (!w_fmt_onehot) begin
                    w_next = S_TRAP;
                end else begin
                    w_next = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                if (w_is_branch) begin
                    // Branches finish here: no register write, PC resolved now.
                    w_pc_we  = 1'b1;
                    w_pc_sel = i_branch_taken ? PC_IMM : PC_PLUS4;
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end else if (w_is_load || w_is_store) begin
                    w_next = S_MEM;
                end else begin
                    w_next = S_WB;
                end
            end
            S_MEM: begin
                // Only loads and stores reach MEM, so non-load means store.
                if (w_is_load) w_dmem_ren = 1'b1;
                else           w_dmem_wen = 1'b1;
                if (i_dmem_ready) begin
                    if (w_is_load) begin
                        w_next = S_WB;
                    end else begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_WB: begin
                w_rf_we  = 1'b1;
                w_pc_we  = 1'b1;
                w_retire = 1'b1;
                if (w_is_jal)       w_pc_sel = PC_IMM;
                else if (w_is_jalr) w_pc_sel = PC_JALR;
                w_next = S_FETCH;
            end
            S_HALT:  w_next = S_HALT;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_TRAP;
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    // Wait counter: restarts on every transition, counts not-ready FETCH/MEM cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst)                  r_wait_cnt <= 8'd0;
        else if (w_next != r_state) r_wait_cnt <= 8'd0;
        else if (w_waiting)         r_wait_cnt <= r_wait_cnt + 8'd1;
    end

    // Retired-instruction counter, wraps naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst)         r_retired <= '0;
        else if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end

    // Reset kills every strobe combinationally so memory requests drop immediately.
    assign o_imem_req = w_imem_req & ~i_rst;
    assign o_ir_we    = w_ir_we    & ~i_rst;
    assign o_pc_we    = w_pc_we    & ~i_rst;
    assign o_pc_sel   = i_rst ? PC_PLUS4 : w_pc_sel;
    assign o_rf_we    = w_rf_we    & ~i_rst;
    assign o_dmem_ren = w_dmem_ren & ~i_rst;
    assign o_dmem_wen = w_dmem_wen & ~i_rst;
    assign o_retire   = w_retire   & ~i_rst;
    assign o_halt     = (r_state == S_HALT) & ~i_rst;
    assign o_trap     = (r_state == S_TRAP) & ~i_rst;
    assign o_state    = r_state;
    assign o_retired  = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed per-cycle vectors; stimulus pushes the expected
// state/strobes/count for each cycle, a negedge monitor pops and compares.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic [6:0]  i_opcode = 7'd0;
    logic [5:0]  i_format = 6'd0;
    logic        i_ebreak = 1'b0;
    logic        i_branch_taken = 1'b0;
    logic        i_imem_ready = 1'b0;
    logic        i_dmem_ready = 1'b0;
    logic        o_imem_req, o_ir_we, o_pc_we, o_rf_we, o_dmem_ren, o_dmem_wen;
    logic        o_retire, o_halt, o_trap;
    logic [1:0]  o_pc_sel;
    logic [2:0]  o_state;
    logic [31:0] o_retired;

    multicycle_ctrl #(.CNT_W(32), .TIMEOUT(16)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_opcode(i_opcode), .i_format(i_format),
        .i_ebreak(i_ebreak), .i_branch_taken(i_branch_taken),
        .i_imem_ready(i_imem_ready), .i_dmem_ready(i_dmem_ready),
        .o_imem_req(o_imem_req), .o_ir_we(o_ir_we), .o_pc_we(o_pc_we),
        .o_pc_sel(o_pc_sel), .o_rf_we(o_rf_we), .o_dmem_ren(o_dmem_ren),
        .o_dmem_wen(o_dmem_wen), .o_retire(o_retire), .o_halt(o_halt),
        .o_trap(o_trap), .o_state(o_state), .o_retired(o_retired)
    );

    always #5 clk = ~clk;

    // Strobe vector: {imem_req, ir_we, pc_we, pc_sel[1:0], rf_we, ren, wen, retire, halt, trap}
    localparam logic [10:0] NONE    = 11'b000_0000_0000;
    localparam logic [10:0] F_WAIT  = 11'b100_0000_0000;
    localparam logic [10:0] F_GO    = 11'b110_0000_0000;
    localparam logic [10:0] WB0     = 11'b001_0010_0100;
    localparam logic [10:0] WBJ     = 11'b001_0110_0100;
    localparam logic [10:0] WBR     = 11'b001_1010_0100;
    localparam logic [10:0] BR_T    = 11'b001_0100_0100;
    localparam logic [10:0] BR_N    = 11'b001_0000_0100;
    localparam logic [10:0] LD      = 11'b000_0001_0000;
    localparam logic [10:0] ST      = 11'b000_0000_1000;
    localparam logic [10:0] ST_DONE = 11'b001_0000_1100;
    localparam logic [10:0] HALTB   = 11'b000_0000_0010;
    localparam logic [10:0] TRAPB   = 11'b000_0000_0001;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [10:0] sb;
        logic [31:0] ret;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] er = 32'd0;
    string       cur_tag = "init";

    // Monitor: compare the DUT's outputs against the expectation for this cycle.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [10:0] act_sb;
            e = q.pop_front();
            act_sb = {o_imem_req, o_ir_we, o_pc_we, o_pc_sel, o_rf_we,
                      o_dmem_ren, o_dmem_wen, o_retire, o_halt, o_trap};
            n_checks++;
            if (o_state !== e.st || act_sb !== e.sb || o_retired !== e.ret) begin
                n_errors++;
                $display("FAIL %s: got state=%0d strobes=%b retired=%0d, want state=%0d strobes=%b retired=%0d",
                         e.tag, o_state, act_sb, o_retired, e.st, e.sb, e.ret);
            end
        end
    end

    // Drive ready inputs for one cycle and record what the DUT must show.
    task automatic cyc(input logic irdy, input logic drdy, input logic [2:0] st, input logic [10:0] sb);
        exp_t e;
        i_imem_ready = irdy;
        i_dmem_ready = drdy;
        e.tag = cur_tag; e.st = st; e.sb = sb; e.ret = er;
        q.push_back(e);
        if (sb[2]) er = er + 32'd1;
        @(posedge clk); #1;
    endtask

    task automatic instr(input string tag, input logic [6:0] op, input logic [5:0] fmt,
                         input logic eb, input logic tk);
        cur_tag = tag;
        i_opcode = op; i_format = fmt; i_ebreak = eb; i_branch_taken = tk;
    endtask

    // Raise reset in a cycle whose pre-reset state is st_now, hold one more cycle.
    task automatic do_reset(input logic [2:0] st_now);
        exp_t e;
        cur_tag = "reset";
        i_rst = 1'b1;
        e.tag = "reset_rise"; e.st = st_now; e.sb = NONE; e.ret = er;
        q.push_back(e);
        @(posedge clk); #1;
        er = 32'd0;
        e.tag = "reset_hold"; e.st = 3'd0; e.sb = NONE; e.ret = 32'd0;
        q.push_back(e);
        @(posedge clk); #1;
        i_rst = 1'b0;
    endtask

    initial begin
        @(posedge clk); #1;
        do_reset(3'd0);

        // add: 0,1,2,4
        instr("add", 7'b0110011, 6'b000001, 1'b0, 1'b0);
        cyc(1, 1, 0, F_GO); cyc(1, 1, 1, NONE); cyc(1, 1, 2, NONE); cyc(1, 1, 4, WB0);

        // lw with 3 dmem wait cycles: 8 cycles total
        instr("lw", 7'b0000011, 6'b000010, 1'b0, 1'b0);
        cyc(1, 0, 0, F_GO); cyc(1, 0, 1, NONE); cyc(1, 0, 2, NONE);
        cyc(1, 0, 3, LD); cyc(1, 0, 3, LD); cyc(1, 0, 3, LD); cyc(1, 1, 3, LD);
        cyc(1, 1, 4, WB0);

        // beq taken then not taken
        instr("beq_t", 7'b1100011, 6'b001000, 1'b0, 1'b1);
        cyc(1, 1, 0, F_GO); cyc(1, 1, 1, NONE); cyc(1, 1, 2, BR_T);
        instr("beq_n", 7'b1100011, 6'b001000, 1'b0, 1'b0);
        cyc(1, 1, 0, F_GO); cyc(1, 1, 1, NONE); cyc(1, 1, 2, BR_N);

        // jal and jalr
        instr("jal", 7'b1101111, 6'b100000, 1'b0, 1'b0);
        cyc(1, 1, 0, F_GO); cyc(1, 1, 1, NONE); cyc(1, 1, 2, NONE); cyc(1, 1, 4, WBJ);
        instr("jalr", 7'b1100111, 6'b000010, 1'b0, 1'b0);
        cyc(1, 1, 0, F_GO); cyc(1, 1, 1, NONE); cyc(1, 1, 2, NONE); cyc(1, 1, 4, WBR);

        // lui (U-type) with one fetch wait cycle
        instr("lui", 7'b0110111, 6'b010000, 1'b0, 1'b0);
        cyc(0, 1, 0, F_WAIT); cyc(1, 1, 0, F_GO); cyc(1, 1, 1, NONE); cyc(1, 1, 2, NONE);
        cyc(1, 1, 4, WB0);

        // sw with one dmem wait cycle
        instr("sw", 7'b0100011, 6'b000100, 1'b0, 1'b0);
        cyc(1, 0, 0, F_GO); cyc(1, 0, 1, NONE); cyc(1, 0, 2, NONE);
        cyc(1, 0, 3, ST); cyc(1, 1, 3, ST_DONE);

        // fetch timeout: 16 waiting cycles, then TRAP (absorbing)
        instr("fetch_to", 7'b0110011, 6'b000001, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) cyc(0, 0, 0, F_WAIT);
        cur_tag = "trap_hold";
        for (int i = 0; i < 4; i++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6, TRAPB);
        do_reset(3'd6);

        // ready in the 16th fetch cycle is accepted
        instr("fetch_16", 7'b0110011, 6'b000001, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) cyc(0, 0, 0, F_WAIT);
        cyc(1, 0, 0, F_GO); cyc(1, 1, 1, NONE); cyc(1, 1, 2, NONE); cyc(1, 1, 4, WB0);

        // store MEM timeout
        instr("mem_to", 7'b0100011, 6'b000100, 1'b0, 1'b0);
        cyc(1, 0, 0, F_GO); cyc(1, 0, 1, NONE); cyc(1, 0, 2, NONE);
        for (int i = 0; i < 16; i++) cyc(1, 0, 3, ST);
        cyc(1, 1, 6, TRAPB);
        do_reset(3'd6);

        // ebreak -> HALT, persists under random inputs
        instr("ebreak", 7'b1110011, 6'b000010, 1'b1, 1'b0);
        cyc(1, 1, 0, F_GO); cyc(1, 1, 1, NONE);
        cur_tag = "halt_hold";
        for (int i = 0; i < 5; i++) begin
            i_opcode = 7'($urandom); i_format = 6'($urandom);
            i_ebreak = 1'($urandom); i_branch_taken = 1'($urandom);
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5, HALTB);
        end
        do_reset(3'd5);

        // illegal opcode with format 0 -> TRAP
        instr("illegal", 7'b1111111, 6'b000000, 1'b0, 1'b0);
        cyc(1, 1, 0, F_GO); cyc(1, 1, 1, NONE); cyc(1, 1, 6, TRAPB);
        do_reset(3'd6);

        // ecall -> TRAP
        instr("ecall", 7'b1110011, 6'b000010, 1'b0, 1'b0);
        cyc(1, 1, 0, F_GO); cyc(1, 1, 1, NONE); cyc(1, 1, 6, TRAPB);
        do_reset(3'd6);

        // format not one-hot -> TRAP
        instr("fmt_2hot", 7'b0110011, 6'b000011, 1'b0, 1'b0);
        cyc(1, 1, 0, F_GO); cyc(1, 1, 1, NONE); cyc(1, 1, 6, TRAPB);
        do_reset(3'd6);

        // retire one add so the counter is nonzero, then reset mid-store wait
        instr("add2", 7'b0110011, 6'b000001, 1'b0, 1'b0);
        cyc(1, 1, 0, F_GO); cyc(1, 1, 1, NONE); cyc(1, 1, 2, NONE); cyc(1, 1, 4, WB0);
        instr("sw_rst", 7'b0100011, 6'b000100, 1'b0, 1'b0);
        cyc(1, 0, 0, F_GO); cyc(1, 0, 1, NONE); cyc(1, 0, 2, NONE);
        cyc(1, 0, 3, ST); cyc(1, 0, 3, ST);
        do_reset(3'd3);
        cur_tag = "post_rst";
        cyc(1, 1, 0, F_GO);

        repeat (4) @(posedge clk);
        if (q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
